// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the buffered 8N1 UART transmitter.
//   Contents:
//     tx_state_e     - serializer FSM states (IDLE, START, DATA, STOP)
//     FRAME_BITS     - line bits per 8N1 frame (start + 8 data + stop)
//     clks_per_bit() - clock cycles per line bit, rounded to nearest
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int FRAME_BITS = 10;

    // Adding half the baud rate before dividing rounds to nearest rather than
    // truncating, keeping the bit-time error below half a clock.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock circular FIFO with show-ahead read data.
//   Parameters: WIDTH (entry width), DEPTH (entries, power of two, >= 2).
//   Ports:
//     clk, reset   - clock, asynchronous active-high reset
//     push         - write request; ignored while full
//     push_data    - data written on an accepted push
//     pop          - read request; ignored while empty
//     head_data    - oldest entry, valid whenever empty is low
//     full, empty  - occupancy flags, derived from the registered count
//     count        - current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE    = AW'(1);
    localparam logic [AW:0]    CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Flags come from the registered count only, so a push decision never
    // depends combinationally on a pop in the same cycle.
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by overflow.
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; the cleared count and pointers
    // already mark every entry invalid, and an unreset array maps to RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered 8N1 UART transmitter. Bytes enter a FIFO through a valid/ready
//   push interface and are serialized LSB-first; queued frames are sent
//   back-to-back with no idle gap between stop and the next start bit.
//   Parameters: CLK_HZ, BAUD, DEPTH (FIFO entries, power of two, >= 2).
//   Ports:
//     clk, reset  - clock, asynchronous active-high reset
//     tx_req      - push request; accepted on an edge where tx_ready is high
//     tx_data     - byte pushed on accept
//     tx_ready    - FIFO not full
//     busy        - a frame is on the line or the FIFO holds data
//     fifo_count  - FIFO occupancy
//     uart_tx     - serial line, idle high
// ---------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 25000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tx_req,
    input  logic [7:0]             tx_data,
    output logic                   tx_ready,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   uart_tx
);

    // Must come out at 2 or more for the baud counter to be meaningful.
    localparam int            CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int            CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_ONE     = CW'(1);
    localparam int            DATA_BITS    = FRAME_BITS - 2;
    localparam logic [2:0]    LAST_BIT     = 3'(DATA_BITS - 1);

    tx_state_e     state, state_nx;
    logic [CW-1:0] baud_cnt, baud_nx;
    logic [2:0]    bit_idx, bit_nx;
    logic [7:0]    shift_reg, shift_nx;
    logic          tx_line, line_nx;

    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic          baud_last;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_req),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign tx_ready  = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;
    assign uart_tx   = tx_line;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_line   <= 1'b1;
        end else begin
            state     <= state_nx;
            baud_cnt  <= baud_nx;
            bit_idx   <= bit_nx;
            shift_reg <= shift_nx;
            tx_line   <= line_nx;
        end
    end

    // The line is a register whose next value is chosen here, so each bit
    // change lands exactly on the edge that ends the previous bit time.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // left one unassigned would infer a latch.
        state_nx = state;
        baud_nx  = baud_cnt;
        bit_nx   = bit_idx;
        shift_nx = shift_reg;
        line_nx  = tx_line;
        fifo_pop = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_nx = fifo_head;
                    line_nx  = 1'b0;
                    baud_nx  = '0;
                    state_nx = START;
                end
            end

            START: begin
                if (baud_last) begin
                    baud_nx  = '0;
                    bit_nx   = '0;
                    line_nx  = shift_reg[0];
                    state_nx = DATA;
                end else begin
                    baud_nx = baud_cnt + BAUD_ONE;
                end
            end

            DATA: begin
                if (baud_last) begin
                    baud_nx = '0;
                    if (bit_idx == LAST_BIT) begin
                        line_nx  = 1'b1;
                        state_nx = STOP;
                    end else begin
                        // Shift right so the next bit to send is always bit 1.
                        bit_nx   = bit_idx + 3'd1;
                        shift_nx = {1'b0, shift_reg[7:1]};
                        line_nx  = shift_reg[1];
                    end
                end else begin
                    baud_nx = baud_cnt + BAUD_ONE;
                end
            end

            STOP: begin
                if (baud_last) begin
                    baud_nx = '0;
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit: no idle gap.
                        fifo_pop = 1'b1;
                        shift_nx = fifo_head;
                        line_nx  = 1'b0;
                        state_nx = START;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    baud_nx = baud_cnt + BAUD_ONE;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

endmodule
